alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 123 ++++++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards rs/rt, picks operand B (register or formatted immediate)
// and registers both operands plus store data for the execute stage.
module alu_operand_stage #(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     readDataUm,
   input  logic [WIDTH-1:0]     readDataDois,
   input  logic [IMM_WIDTH-1:0] imm,
   input  logic [1:0]           aluSrc,
   input  logic [1:0]           fwdA,
   input  logic [1:0]           fwdB,
   input  logic [WIDTH-1:0]     exMemResult,
   input  logic [WIDTH-1:0]     memWbResult,
   output logic [WIDTH-1:0]     aluInUm,
   output logic [WIDTH-1:0]     aluInDois,
   output logic [WIDTH-1:0]     storeData,
   output logic                 out_valid,
   output logic [7:0]           stallCount
);

   localparam int LUI_SHIFT = WIDTH - IMM_WIDTH;

   logic [WIDTH-1:0] rsF, rtF;
   logic [WIDTH-1:0] immSext, immZext, immLui, opB;

   logic [WIDTH-1:0] aluInUm_q, aluInUm_d;
   logic [WIDTH-1:0] aluInDois_q, aluInDois_d;
   logic [WIDTH-1:0] storeData_q, storeData_d;
   logic             outValid_q, outValid_d;
   logic [7:0]       stallCount_q, stallCount_d;

   // Forwarding muxes; code 11 aliases the EX/MEM result.
   always_comb begin
      unique case (fwdA)
         2'b00:   rsF = readDataUm;
         2'b10:   rsF = memWbResult;
         default: rsF = exMemResult;
      endcase
      unique case (fwdB)
         2'b00:   rtF = readDataDois;
         2'b10:   rtF = memWbResult;
         default: rtF = exMemResult;
      endcase
   end

   always_comb begin
      immSext                  = {WIDTH{imm[IMM_WIDTH-1]}};
      immSext[IMM_WIDTH-1:0]   = imm;
      immZext                  = '0;
      immZext[IMM_WIDTH-1:0]   = imm;
      immLui                   = immZext << LUI_SHIFT;
      unique case (aluSrc)
         2'b00:   opB = rtF;
         2'b01:   opB = immSext;
         2'b10:   opB = immZext;
         default: opB = immLui;
      endcase
   end

   // Next state with priority flush > stall > load; stall cycles are only
   // counted while a valid operand set is being held.
   always_comb begin
      aluInUm_d    = aluInUm_q;
      aluInDois_d  = aluInDois_q;
      storeData_d  = storeData_q;
      outValid_d   = outValid_q;
      stallCount_d = stallCount_q;
      if (flush) begin
         aluInUm_d    = '0;
         aluInDois_d  = '0;
         storeData_d  = '0;
         outValid_d   = 1'b0;
         stallCount_d = 8'd0;
      end else if (stall) begin
         if (outValid_q)
            stallCount_d = (stallCount_q == 8'hFF) ? stallCount_q : stallCount_q + 8'd1;
         else
            stallCount_d = 8'd0;
      end else begin
         stallCount_d = 8'd0;
         if (in_valid) begin
            aluInUm_d   = rsF;
            aluInDois_d = opB;
            storeData_d = rtF;
            outValid_d  = 1'b1;
         end else begin
            aluInUm_d   = '0;
            aluInDois_d = '0;
            storeData_d = '0;
            outValid_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aluInUm_q    <= '0;
         aluInDois_q  <= '0;
         storeData_q  <= '0;
         outValid_q   <= 1'b0;
         stallCount_q <= 8'd0;
      end else begin
         aluInUm_q    <= aluInUm_d;
         aluInDois_q  <= aluInDois_d;
         storeData_q  <= storeData_d;
         outValid_q   <= outValid_d;
         stallCount_q <= stallCount_d;
      end
   end

   assign aluInUm    = aluInUm_q;
   assign aluInDois  = aluInDois_q;
   assign storeData  = storeData_q;
   assign out_valid  = outValid_q;
   assign stallCount = stallCount_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: 32-bit and 64-bit instances driven with shared
// controls, checked against a behavioural model of the operand stage.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, stall, flush;
   logic [15:0] imm;
   logic [1:0]  aluSrc, fwdA, fwdB;

   logic [31:0] a32, b32, e32, w32;
   logic [63:0] a64, b64, e64, w64;

   logic [31:0] um32, dois32, sd32;
   logic        v32;
   logic [7:0]  sc32;
   logic [63:0] um64, dois64, sd64;
   logic        v64;
   logic [7:0]  sc64;

   // Model state: index 0 is the 32-bit instance, index 1 the 64-bit one.
   logic [63:0] mA[2], mB[2], mS[2];
   logic        mV[2];
   int          mC[2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.WIDTH(32), .IMM_WIDTH(16)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .readDataUm(a32), .readDataDois(b32), .imm(imm), .aluSrc(aluSrc),
      .fwdA(fwdA), .fwdB(fwdB), .exMemResult(e32), .memWbResult(w32),
      .aluInUm(um32), .aluInDois(dois32), .storeData(sd32), .out_valid(v32),
      .stallCount(sc32)
   );

   alu_operand_stage #(.WIDTH(64), .IMM_WIDTH(16)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .readDataUm(a64), .readDataDois(b64), .imm(imm), .aluSrc(aluSrc),
      .fwdA(fwdA), .fwdB(fwdB), .exMemResult(e64), .memWbResult(w64),
      .aluInUm(um64), .aluInDois(dois64), .storeData(sd64), .out_valid(v64),
      .stallCount(sc64)
   );

   function automatic logic [63:0] widthMask(int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] pickSource(logic [1:0] code, logic [63:0] rf,
                                               logic [63:0] ex, logic [63:0] wb);
      if (code == 2'd0) return rf;
      if (code == 2'd2) return wb;
      return ex;
   endfunction

   // Operand B from the immediate rules, using plain arithmetic on the value.
   function automatic logic [63:0] operandB(int w, logic [1:0] src, logic [63:0] rt,
                                             logic [15:0] im);
      longint s;
      case (src)
         2'd0: return rt;
         2'd1: begin
            s = im[15] ? longint'(im) - 65536 : longint'(im);
            return 64'(s) & widthMask(w);
         end
         2'd2: return 64'(im);
         default: return (64'(im) << (w - 16)) & widthMask(w);
      endcase
   endfunction

   task automatic modelEdge(int k, int w, logic [63:0] ra, logic [63:0] rb,
                            logic [63:0] ex, logic [63:0] wb);
      logic [63:0] rs, rt;
      rs = pickSource(fwdA, ra, ex, wb);
      rt = pickSource(fwdB, rb, ex, wb);
      if (flush) begin
         mA[k] = '0; mB[k] = '0; mS[k] = '0; mV[k] = 1'b0; mC[k] = 0;
      end else if (stall) begin
         mC[k] = mV[k] ? ((mC[k] < 255) ? mC[k] + 1 : 255) : 0;
      end else begin
         mC[k] = 0;
         if (in_valid) begin
            mA[k] = rs; mB[k] = operandB(w, aluSrc, rt, imm); mS[k] = rt; mV[k] = 1'b1;
         end else begin
            mA[k] = '0; mB[k] = '0; mS[k] = '0; mV[k] = 1'b0;
         end
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mA[k] = '0; mB[k] = '0; mS[k] = '0; mV[k] = 1'b0; mC[k] = 0;
      end
   endtask

   // Advance one rising edge, updating the model from the inputs the DUT samples.
   task automatic applyStimulus();
      modelEdge(0, 32, 64'(a32), 64'(b32), 64'(e32), 64'(w32));
      modelEdge(1, 64, a64, b64, e64, w64);
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkVal("aluInUm32",    64'(um32),   mA[0]);
      checkVal("aluInDois32",  64'(dois32), mB[0]);
      checkVal("storeData32",  64'(sd32),   mS[0]);
      checkVal("outValid32",   64'(v32),    64'(mV[0]));
      checkVal("stallCount32", 64'(sc32),   64'(mC[0]));
      checkVal("aluInUm64",    um64,        mA[1]);
      checkVal("aluInDois64",  dois64,      mB[1]);
      checkVal("storeData64",  sd64,        mS[1]);
      checkVal("outValid64",   64'(v64),    64'(mV[1]));
      checkVal("stallCount64", 64'(sc64),   64'(mC[1]));
   endtask

   task automatic randomizeData();
      a32 = $urandom; b32 = $urandom; e32 = $urandom; w32 = $urandom;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      e64 = {$urandom, $urandom}; w64 = {$urandom, $urandom};
   endtask

   task automatic setData(logic [63:0] a, logic [63:0] b, logic [63:0] e, logic [63:0] w);
      a32 = a[31:0]; b32 = b[31:0]; e32 = e[31:0]; w32 = w[31:0];
      a64 = a; b64 = b; e64 = e; w64 = w;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      imm = '0; aluSrc = '0; fwdA = '0; fwdB = '0;
      setData(64'd0, 64'd0, 64'd0, 64'd0);
      modelReset();
      #2;
      checkOutput();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Sign-extended immediate with rs straight from the register file.
      in_valid = 1'b1; aluSrc = 2'b01; imm = 16'h8000; fwdA = 2'b00; fwdB = 2'b00;
      setData(64'd5, 64'd11, 64'd21, 64'd31);
      applyStimulus();
      checkOutput();
      checkVal("req035_a32", 64'(um32), 64'd5);
      checkVal("req035_b32", 64'(dois32), 64'h0000_0000_FFFF_8000);
      checkVal("req035_b64", dois64, 64'hFFFF_FFFF_FFFF_8000);
      checkVal("req035_v", 64'(v32), 64'd1);

      aluSrc = 2'b10; imm = 16'h8000;
      applyStimulus();
      checkOutput();
      checkVal("zext32", 64'(dois32), 64'h0000_8000);
      aluSrc = 2'b11; imm = 16'h1234;
      applyStimulus();
      checkOutput();
      checkVal("lui32", 64'(dois32), 64'h1234_0000);
      checkVal("lui64", dois64, 64'h1234_0000_0000_0000);

      // Forwarding on both operands while B takes the immediate.
      aluSrc = 2'b01; imm = 16'h8000; fwdB = 2'b10; fwdA = 2'b11;
      setData(64'd5, 64'd7, 64'd3, 64'd9);
      applyStimulus();
      checkOutput();
      checkVal("fwd_store32", 64'(sd32), 64'd9);
      checkVal("fwd_rs32", 64'(um32), 64'd3);
      checkVal("fwd_b32", 64'(dois32), 64'hFFFF_8000);

      for (int i = 0; i < 60; i++) begin
         randomizeData();
         imm = 16'($urandom); aluSrc = 2'($urandom); fwdA = 2'($urandom); fwdB = 2'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         applyStimulus();
         checkOutput();
      end

      // Long stall: outputs frozen while the counter saturates.
      stall = 1'b0; flush = 1'b0; in_valid = 1'b1; aluSrc = 2'b00; fwdA = 2'b00; fwdB = 2'b00;
      randomizeData();
      applyStimulus();
      checkOutput();
      stall = 1'b1;
      for (int i = 0; i < 300; i++) begin
         randomizeData();
         imm = 16'($urandom); aluSrc = 2'($urandom); fwdA = 2'($urandom); fwdB = 2'($urandom);
         applyStimulus();
         checkOutput();
      end
      checkVal("stallSat32", 64'(sc32), 64'd255);
      checkVal("stallSat64", 64'(sc64), 64'd255);
      stall = 1'b0;
      applyStimulus();
      checkOutput();
      checkVal("stallClr32", 64'(sc32), 64'd0);

      // Flush beats stall; then an invalid load inserts a bubble.
      stall = 1'b1;
      applyStimulus();
      flush = 1'b1;
      applyStimulus();
      checkOutput();
      checkVal("flushValid", 64'(v32), 64'd0);
      flush = 1'b0; stall = 1'b0;
      applyStimulus();
      checkOutput();
      in_valid = 1'b0;
      applyStimulus();
      checkOutput();
      checkVal("bubbleValid", 64'(v64), 64'd0);

      // Reset arrives between edges in the middle of a stall.
      in_valid = 1'b1; randomizeData();
      applyStimulus();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput();
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput();
      @(posedge clk); #1;
      checkOutput();
      reset = 1'b0; stall = 1'b0; randomizeData();
      applyStimulus();
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
